riscv_multi_ctrl: RTL and testbench
===================================

Name: riscv_multi_ctrl

Overview:
- Main control FSM for the multicycle RISC-V datapath. Generalised successor of the hard-wired control signal set.
- Sequences the instruction through FETCH / DECODE / execute / memory / writeback and drives every datapath control strobe.
- Adds a ready-based memory handshake, a bus watchdog, optional JAL support, a sticky trap state and a retired-instruction counter.
- Sits between the instruction register's opcode field and the datapath muxes and enables.

Parameters:
- HAS_JAL, 1, 1 enables decode of JAL (1101111); 0 treats it as illegal.
- MAX_WAIT, 16, max cycles a memory state waits for mem_ready before trapping; 0 disables the watchdog.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write (SW) access
- IorD  out  1  0: PC addresses memory; 1: ALUOut addresses memory
- IRWrite  out  1  load IR from memory read data
- RegWrite  out  1  register file write
- MemtoReg  out  2  00: ALUOut; 01: MDR; 10: PC (link)
- ALUSrcA  out  1  0: PC; 1: register A
- ALUSrcB  out  2  00: B; 01: constant 4; 10: immediate
- ALUop  out  2  00: add; 01: subtract; 10: funct field
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  PC write qualified by ALU zero
- PCSource  out  2  00: ALU result; 01: ALUOut
- retire  out  1  one-cycle pulse when an instruction completes
- retired_cnt  out  CNT_WIDTH  retired-instruction count
- illegal  out  1  sticky: trapped on an illegal opcode
- bus_err  out  1  sticky: trapped on a watchdog timeout
- halted  out  1  sticky: in TRAP

Behaviour:
- State register:
  - rst asynchronously forces state FETCH, wait counter 0, retired_cnt 0, illegal/bus_err/halted 0.
  - While rst is high, every control output is forced to 0.
- Outputs are combinational from state. The only Mealy terms are the mem_ready qualifiers stated below.
- Any output not listed for a state is 0.
- FETCH:
  - Drives mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
  - IRWrite = PCWrite = mem_ready.
  - Goes to DECODE when mem_ready; otherwise stays.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=10, ALUop=00, so ALUOut holds the branch/jump target.
  - Next state by opcode: 0000011 or 0100011 -> MEM_ADDR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 with HAS_JAL=1 -> JAL; any other value -> TRAP with illegal set.
- MEM_ADDR:
  - Drives ALUSrcA=1, ALUSrcB=10, ALUop=00.
  - Next is MEM_READ for LW, MEM_WRITE for SW; opcode is still held in IR.
- MEM_READ:
  - Drives mem_req=1, IorD=1.
  - Goes to MEM_WB on mem_ready.
- MEM_WB: RegWrite=1, MemtoReg=01, retire=1, then FETCH.
- MEM_WRITE:
  - Drives mem_req=1, mem_we=1, IorD=1.
  - On mem_ready: retire=1, then FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUop=10, then ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUop=10, then ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=00, retire=1, then FETCH.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01, retire=1.
  - Then FETCH.
- JAL:
  - Drives RegWrite=1, MemtoReg=10 (PC, already +4), PCWrite=1, PCSource=01, retire=1.
  - Then FETCH.
- TRAP:
  - Absorbing; all control outputs 0, halted=1.
  - Left only by rst.
- Latencies (without memory wait):
  - LW: 5 cycles.
  - SW, R-type, I-type: 4 cycles.
  - BEQ and JAL: 3 cycles.
  - Each mem_ready-low cycle adds 1.
- Watchdog (MAX_WAIT>0):
  - Counts consecutive mem_ready-low cycles in FETCH, MEM_READ and MEM_WRITE.
  - Clears on state exit.
  - When the count reaches MAX_WAIT while mem_ready is still low, the next state is TRAP and bus_err is set.
  - mem_ready on the same cycle as the count reaching MAX_WAIT wins: normal transition, no error.
- retired_cnt increments on every retire cycle and wraps from all-ones to 0 without any flag.
- Reset mid-instruction: the instruction is abandoned, no retire pulse, and state returns to FETCH immediately (asynchronously).

Test Plan:
- Reset, then opcode 0110011 with mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, ALU_WB. RegWrite=1 and retire=1 only in cycle 4; retired_cnt=1.
- LW with mem_ready low for 3 cycles in MEM_READ -> 8 cycles total. IorD=1 and mem_req=1 are held throughout the wait; MemtoReg=01 in MEM_WB; bus_err=0.
- SW with mem_ready high -> mem_we=1 for exactly 1 cycle, in MEM_WRITE; RegWrite never asserted.
- opcode 1101111 -> with HAS_JAL=1: JAL state with PCWrite=1, MemtoReg=10, 3-cycle retire. With HAS_JAL=0: TRAP, illegal=1, halted=1; a later rst pulse clears all three.
- MAX_WAIT=4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles with bus_err=1. Repeating with mem_ready=1 on the 4th wait cycle -> DECODE, no error.
- CNT_WIDTH=4, 16 back-to-back BEQ instructions -> retired_cnt wraps 15 -> 0. A rst asserted mid-DECODE forces FETCH and all outputs 0 within the same cycle.

Source files
------------

// File: rtl/riscv_multi_ctrl_if.sv
// Memory-side handshake between the multicycle control FSM and the memory port.
// The controller is the master: it issues requests and observes mem_ready.
interface riscv_multi_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic IorD;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output IorD, input mem_ready);
  modport slave  (input mem_req, input mem_we, input IorD, output mem_ready);
endinterface

// File: rtl/riscv_multi_ctrl.sv
// Main control FSM for the multicycle RISC-V datapath: sequences each instruction,
// drives every datapath strobe, watches the memory handshake and counts retirements.
module riscv_multi_ctrl #(
  parameter int          HAS_JAL   = 1,
  parameter int unsigned MAX_WAIT  = 16,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [6:0]               opcode,
  riscv_multi_ctrl_if.master       bus,
  output logic                     IRWrite,
  output logic                     RegWrite,
  output logic [1:0]               MemtoReg,
  output logic                     ALUSrcA,
  output logic [1:0]               ALUSrcB,
  output logic [1:0]               ALUop,
  output logic                     PCWrite,
  output logic                     PCWriteCond,
  output logic [1:0]               PCSource,
  output logic                     retire,
  output logic [CNT_WIDTH-1:0]     retired_cnt,
  output logic                     illegal,
  output logic                     bus_err,
  output logic                     halted
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       retire;
  } ctrl_t;

  state_t                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d, wait_inc;
  logic [CNT_WIDTH-1:0]   retired_cnt_q, retired_cnt_d;
  logic                   illegal_q, illegal_d;
  logic                   bus_err_q, bus_err_d;
  logic                   halted_q, halted_d;
  logic                   timeout;
  logic                   mem_state;
  state_t                 mem_next;
  ctrl_t                  ctl, ctl_out;

  assign wait_inc = wait_q + WAIT_W'(1);
  // The cycle that would bring the count to MAX_WAIT traps unless mem_ready rescues it.
  assign timeout  = (MAX_WAIT != 0) && !bus.mem_ready && (wait_inc == WAIT_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      wait_q        <= '0;
      retired_cnt_q <= '0;
      illegal_q     <= 1'b0;
      bus_err_q     <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      retired_cnt_q <= retired_cnt_d;
      illegal_q     <= illegal_d;
      bus_err_q     <= bus_err_d;
      halted_q      <= halted_d;
    end
  end

  always_comb begin
    ctl       = '0;
    state_d   = state_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    mem_state = 1'b0;
    mem_next  = S_FETCH;

    case (state_q)
      S_FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.ir_write  = bus.mem_ready;
        ctl.pc_write  = bus.mem_ready;
        mem_state     = 1'b1;
        mem_next      = S_DECODE;
      end
      S_DECODE: begin
        ctl.alu_src_b = 2'b10;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL: begin
            if (HAS_JAL != 0) begin
              state_d = S_JAL;
            end else begin
              state_d   = S_TRAP;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_d       = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
        mem_state   = 1'b1;
        mem_next    = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 2'b01;
        ctl.retire     = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctl.mem_req = 1'b1;
        ctl.mem_we  = 1'b1;
        ctl.iord    = 1'b1;
        ctl.retire  = bus.mem_ready;
        mem_state   = 1'b1;
        mem_next    = S_FETCH;
      end
      S_EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
        state_d       = S_ALU_WB;
      end
      S_EXEC_I: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_op    = 2'b10;
        state_d       = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctl.reg_write = 1'b1;
        ctl.retire    = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = 2'b01;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 2'b01;
        ctl.retire        = 1'b1;
        state_d           = S_FETCH;
      end
      S_JAL: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 2'b10;
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = 2'b01;
        ctl.retire     = 1'b1;
        state_d        = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Shared wait/watchdog handling for every state that holds a memory request.
    if (mem_state) begin
      if (bus.mem_ready) begin
        state_d = mem_next;
      end else if (timeout) begin
        state_d   = S_TRAP;
        bus_err_d = 1'b1;
      end else begin
        wait_d = wait_inc;
      end
    end
  end

  assign halted_d      = (state_d == S_TRAP);
  assign retired_cnt_d = ctl.retire ? retired_cnt_q + CNT_WIDTH'(1) : retired_cnt_q;

  assign ctl_out = rst ? '0 : ctl;

  assign bus.mem_req  = ctl_out.mem_req;
  assign bus.mem_we   = ctl_out.mem_we;
  assign bus.IorD     = ctl_out.iord;
  assign IRWrite      = ctl_out.ir_write;
  assign RegWrite     = ctl_out.reg_write;
  assign MemtoReg     = ctl_out.mem_to_reg;
  assign ALUSrcA      = ctl_out.alu_src_a;
  assign ALUSrcB      = ctl_out.alu_src_b;
  assign ALUop        = ctl_out.alu_op;
  assign PCWrite      = ctl_out.pc_write;
  assign PCWriteCond  = ctl_out.pc_write_cond;
  assign PCSource     = ctl_out.pc_source;
  assign retire       = ctl_out.retire;
  assign retired_cnt  = retired_cnt_q;
  assign illegal      = illegal_q;
  assign bus_err      = bus_err_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_riscv_multi_ctrl.sv
// Directed bench: dut_a uses default parameters, dut_b uses HAS_JAL=0, MAX_WAIT=4, CNT_WIDTH=4.
module tb_riscv_multi_ctrl;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // {mem_req, mem_we, IorD, IRWrite, RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUop, PCWrite, PCWriteCond, PCSource, retire}
  localparam logic [16:0] C_ZERO  = 17'b0_0_0_0_0_00_0_00_00_0_0_00_0;
  localparam logic [16:0] C_F1    = 17'b1_0_0_1_0_00_0_01_00_1_0_00_0;
  localparam logic [16:0] C_F0    = 17'b1_0_0_0_0_00_0_01_00_0_0_00_0;
  localparam logic [16:0] C_DEC   = 17'b0_0_0_0_0_00_0_10_00_0_0_00_0;
  localparam logic [16:0] C_MADDR = 17'b0_0_0_0_0_00_1_10_00_0_0_00_0;
  localparam logic [16:0] C_MRD   = 17'b1_0_1_0_0_00_0_00_00_0_0_00_0;
  localparam logic [16:0] C_MWB   = 17'b0_0_0_0_1_01_0_00_00_0_0_00_1;
  localparam logic [16:0] C_MWR1  = 17'b1_1_1_0_0_00_0_00_00_0_0_00_1;
  localparam logic [16:0] C_EXR   = 17'b0_0_0_0_0_00_1_00_10_0_0_00_0;
  localparam logic [16:0] C_EXI   = 17'b0_0_0_0_0_00_1_10_10_0_0_00_0;
  localparam logic [16:0] C_AWB   = 17'b0_0_0_0_1_00_0_00_00_0_0_00_1;
  localparam logic [16:0] C_BR    = 17'b0_0_0_0_0_00_1_00_01_0_1_01_1;
  localparam logic [16:0] C_JAL   = 17'b0_0_0_0_1_10_0_00_00_1_0_01_1;

  typedef struct {
    logic        rst;
    logic [6:0]  opc;
    logic        rdy;
    logic [16:0] ctl;
    logic [2:0]  flags;  // {illegal, bus_err, halted}
    logic [31:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] opcode;
  logic mem_ready;
  int total = 0;
  int bad = 0;
  vec_t vecs[$];

  riscv_multi_ctrl_if bus_a ();
  riscv_multi_ctrl_if bus_b ();
  assign bus_a.mem_ready = mem_ready;
  assign bus_b.mem_ready = mem_ready;

  logic IRWrite_a, RegWrite_a, ALUSrcA_a, PCWrite_a, PCWriteCond_a, retire_a;
  logic illegal_a, bus_err_a, halted_a;
  logic [1:0] MemtoReg_a, ALUSrcB_a, ALUop_a, PCSource_a;
  logic [31:0] cnt_a;
  logic IRWrite_b, RegWrite_b, ALUSrcA_b, PCWrite_b, PCWriteCond_b, retire_b;
  logic illegal_b, bus_err_b, halted_b;
  logic [1:0] MemtoReg_b, ALUSrcB_b, ALUop_b, PCSource_b;
  logic [3:0] cnt_b;

  riscv_multi_ctrl dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .bus(bus_a),
    .IRWrite(IRWrite_a), .RegWrite(RegWrite_a), .MemtoReg(MemtoReg_a), .ALUSrcA(ALUSrcA_a),
    .ALUSrcB(ALUSrcB_a), .ALUop(ALUop_a), .PCWrite(PCWrite_a), .PCWriteCond(PCWriteCond_a),
    .PCSource(PCSource_a), .retire(retire_a), .retired_cnt(cnt_a), .illegal(illegal_a),
    .bus_err(bus_err_a), .halted(halted_a)
  );

  riscv_multi_ctrl #(.HAS_JAL(0), .MAX_WAIT(4), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .bus(bus_b),
    .IRWrite(IRWrite_b), .RegWrite(RegWrite_b), .MemtoReg(MemtoReg_b), .ALUSrcA(ALUSrcA_b),
    .ALUSrcB(ALUSrcB_b), .ALUop(ALUop_b), .PCWrite(PCWrite_b), .PCWriteCond(PCWriteCond_b),
    .PCSource(PCSource_b), .retire(retire_b), .retired_cnt(cnt_b), .illegal(illegal_b),
    .bus_err(bus_err_b), .halted(halted_b)
  );

  logic [16:0] ctl_a, ctl_b;
  logic [2:0]  flags_a, flags_b;
  assign ctl_a = {bus_a.mem_req, bus_a.mem_we, bus_a.IorD, IRWrite_a, RegWrite_a, MemtoReg_a,
                  ALUSrcA_a, ALUSrcB_a, ALUop_a, PCWrite_a, PCWriteCond_a, PCSource_a, retire_a};
  assign ctl_b = {bus_b.mem_req, bus_b.mem_we, bus_b.IorD, IRWrite_b, RegWrite_b, MemtoReg_b,
                  ALUSrcA_b, ALUSrcB_b, ALUop_b, PCWrite_b, PCWriteCond_b, PCSource_b, retire_b};
  assign flags_a = {illegal_a, bus_err_a, halted_a};
  assign flags_b = {illegal_b, bus_err_b, halted_b};

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [6:0] o, input logic y, input logic [16:0] c,
                     input logic [2:0] f, input logic [31:0] n);
    vec_t v;
    v.rst = r; v.opc = o; v.rdy = y; v.ctl = c; v.flags = f; v.cnt = n;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; opcode = OP_R; mem_ready = 1'b1;

    add(1, OP_R,  1, C_ZERO,  3'b000, 0);
    // R-type
    add(0, OP_R,  1, C_F1,    3'b000, 0);
    add(0, OP_R,  1, C_DEC,   3'b000, 0);
    add(0, OP_R,  1, C_EXR,   3'b000, 0);
    add(0, OP_R,  1, C_AWB,   3'b000, 0);
    // LW with three wait cycles in MEM_READ
    add(0, OP_LW, 1, C_F1,    3'b000, 1);
    add(0, OP_LW, 1, C_DEC,   3'b000, 1);
    add(0, OP_LW, 1, C_MADDR, 3'b000, 1);
    add(0, OP_LW, 0, C_MRD,   3'b000, 1);
    add(0, OP_LW, 0, C_MRD,   3'b000, 1);
    add(0, OP_LW, 0, C_MRD,   3'b000, 1);
    add(0, OP_LW, 1, C_MRD,   3'b000, 1);
    add(0, OP_LW, 1, C_MWB,   3'b000, 1);
    // SW
    add(0, OP_SW, 1, C_F1,    3'b000, 2);
    add(0, OP_SW, 1, C_DEC,   3'b000, 2);
    add(0, OP_SW, 1, C_MADDR, 3'b000, 2);
    add(0, OP_SW, 1, C_MWR1,  3'b000, 2);
    // I-type
    add(0, OP_I,  1, C_F1,    3'b000, 3);
    add(0, OP_I,  1, C_DEC,   3'b000, 3);
    add(0, OP_I,  1, C_EXI,   3'b000, 3);
    add(0, OP_I,  1, C_AWB,   3'b000, 3);
    // BEQ
    add(0, OP_BR, 1, C_F1,    3'b000, 4);
    add(0, OP_BR, 1, C_DEC,   3'b000, 4);
    add(0, OP_BR, 1, C_BR,    3'b000, 4);
    // JAL
    add(0, OP_JAL,1, C_F1,    3'b000, 5);
    add(0, OP_JAL,1, C_DEC,   3'b000, 5);
    add(0, OP_JAL,1, C_JAL,   3'b000, 5);
    // FETCH wait of two cycles, then an illegal opcode
    add(0, OP_BAD,0, C_F0,    3'b000, 6);
    add(0, OP_BAD,0, C_F0,    3'b000, 6);
    add(0, OP_BAD,1, C_F1,    3'b000, 6);
    add(0, OP_BAD,1, C_DEC,   3'b000, 6);
    add(0, OP_R,  1, C_ZERO,  3'b101, 6);
    add(0, OP_R,  1, C_ZERO,  3'b101, 6);
    add(1, OP_R,  1, C_ZERO,  3'b000, 0);
    add(0, OP_R,  1, C_F1,    3'b000, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; opcode = vecs[i].opc; mem_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d ctl", i), 32'(ctl_a), 32'(vecs[i].ctl));
      chk($sformatf("v%0d flags", i), 32'(flags_a), 32'(vecs[i].flags));
      chk($sformatf("v%0d cnt", i), cnt_a, vecs[i].cnt);
      $display("vec %0d rst=%0b opc=%b rdy=%0b ctl=%b flags=%b cnt=%0d",
               i, rst, opcode, mem_ready, ctl_a, flags_a, cnt_a);
    end

    // JAL is illegal in dut_b, legal in dut_a
    @(negedge clk); rst = 1'b1; opcode = OP_JAL; mem_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    chk("jal0 b decode", 32'(ctl_b), 32'(C_DEC));
    @(negedge clk); #1;
    chk("jal0 b trap ctl", 32'(ctl_b), 32'(C_ZERO));
    chk("jal0 b flags", 32'(flags_b), 32'(3'b101));
    chk("jal1 a state", 32'(ctl_a), 32'(C_JAL));
    $display("seq jal: ctl_a=%b ctl_b=%b flags_b=%b", ctl_a, ctl_b, flags_b);
    @(negedge clk); rst = 1'b1; #1;
    chk("jal0 b rst flags", 32'(flags_b), 32'(3'b000));
    chk("jal0 b rst ctl", 32'(ctl_b), 32'(C_ZERO));

    // Watchdog: four low cycles in FETCH traps dut_b
    opcode = OP_R; mem_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("wd b wait held", 32'(ctl_b), 32'(C_F0));
    @(negedge clk); #1;
    chk("wd b flags", 32'(flags_b), 32'(3'b011));
    chk("wd b ctl", 32'(ctl_b), 32'(C_ZERO));
    chk("wd a still fetch", 32'(ctl_a), 32'(C_F0));
    chk("wd a flags", 32'(flags_a), 32'(3'b000));
    $display("seq watchdog: flags_b=%b ctl_a=%b", flags_b, ctl_a);

    // mem_ready on the fourth wait cycle rescues the fetch
    @(negedge clk); rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk); mem_ready = 1'b1; #1;
    chk("wd rescue fetch", 32'(ctl_b), 32'(C_F1));
    @(negedge clk); #1;
    chk("wd rescue decode", 32'(ctl_b), 32'(C_DEC));
    chk("wd rescue flags", 32'(flags_b), 32'(3'b000));
    $display("seq rescue: ctl_b=%b flags_b=%b", ctl_b, flags_b);

    // 16 back-to-back BEQ: 4-bit counter wraps
    @(negedge clk); rst = 1'b1; opcode = OP_BR; mem_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (45) @(negedge clk);
    #1;
    chk("wrap b 15", 32'(cnt_b), 32'd15);
    chk("wrap a 15", cnt_a, 32'd15);
    repeat (3) @(negedge clk);
    #1;
    chk("wrap b 0", 32'(cnt_b), 32'd0);
    chk("wrap a 16", cnt_a, 32'd16);
    $display("seq wrap: cnt_a=%0d cnt_b=%0d", cnt_a, cnt_b);

    // Reset mid-DECODE acts without a clock edge
    @(negedge clk); #1;
    chk("mid decode", 32'(ctl_a), 32'(C_DEC));
    #2 rst = 1'b1;
    #2;
    chk("mid rst ctl a", 32'(ctl_a), 32'(C_ZERO));
    chk("mid rst ctl b", 32'(ctl_b), 32'(C_ZERO));
    chk("mid rst cnt a", cnt_a, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("mid rst fetch", 32'(ctl_a), 32'(C_F1));
    $display("seq midrst: ctl_a=%b cnt_a=%0d", ctl_a, cnt_a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
